// File: rtl/sfr_bit_rmw_if.sv
// sfr_bit_rmw_if: core request/response and register-file bus bundle.
// slave = sequencer side, master = core + register-file side.
interface sfr_bit_rmw_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_bit;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_bit;
    logic       rsp_err;
    logic [7:0] sfr_addr;
    logic [7:0] sfr_wdata;
    logic       sfr_wr_en;
    logic [7:0] sfr_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_bit,
        input  sfr_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_bit, rsp_err,
        output sfr_addr, sfr_wdata, sfr_wr_en
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, req_bit,
        output sfr_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_bit, rsp_err,
        input  sfr_addr, sfr_wdata, sfr_wr_en
    );
endinterface

// File: rtl/sfr_bit_rmw.sv
// sfr_bit_rmw: byte/bit SFR request sequencer with read-modify-write
// for bit ops against a register file with a registered read port.
module sfr_bit_rmw (
    input  logic             clock,
    input  logic             reset,
    sfr_bit_rmw_if.slave     bus
);
    localparam logic [2:0] OP_BYTE_RD = 3'd0;
    localparam logic [2:0] OP_BYTE_WR = 3'd1;
    localparam logic [2:0] OP_BIT_RD  = 3'd2;
    localparam logic [2:0] OP_BIT_SET = 3'd3;
    localparam logic [2:0] OP_BIT_CLR = 3'd4;
    localparam logic [2:0] OP_BIT_CPL = 3'd5;
    localparam logic [2:0] OP_BIT_MOV = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RSP
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] op_q;
    logic [2:0] idx_q;
    logic       bit_q;
    logic       err_q;
    logic [7:0] rbuf_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] mask;
    logic [7:0] mod_byte;
    logic       accept;
    logic       req_err;
    logic       op_is_bit;
    logic       op_rd_only;

    assign accept     = (state == S_IDLE) && bus.req_valid;
    assign req_err    = !bus.req_addr[7] || (bus.req_op == OP_RSVD);
    assign mask       = 8'b1 << idx_q;
    assign op_is_bit  = (op_q != OP_BYTE_RD) && (op_q != OP_BYTE_WR);
    assign op_rd_only = (op_q == OP_BYTE_RD) || (op_q == OP_BIT_RD);

    // Modified byte, formed from the registered read data during CAP.
    always_comb begin
        mod_byte = bus.sfr_rdata;
        unique case (1'b1)
            op_q == OP_BIT_SET: mod_byte = bus.sfr_rdata | mask;
            op_q == OP_BIT_CLR: mod_byte = bus.sfr_rdata & ~mask;
            op_q == OP_BIT_CPL: mod_byte = bus.sfr_rdata ^ mask;
            op_q == OP_BIT_MOV: mod_byte = bit_q ? (bus.sfr_rdata | mask)
                                                 : (bus.sfr_rdata & ~mask);
            default:            mod_byte = bus.sfr_rdata;
        endcase
    end

    // Next-state selection for the request sequencer.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_n = S_RSP;
                    else if (bus.req_op == OP_BYTE_WR)
                        state_n = S_WR;
                    else
                        state_n = S_RD;
                end
            end
            S_RD:    state_n = S_CAP;
            S_CAP:   state_n = op_rd_only ? S_RSP : S_WR;
            S_WR:    state_n = S_RSP;
            S_RSP:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Request capture, read buffer and register-file address/data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= OP_BYTE_RD;
            idx_q   <= 3'd0;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
            rbuf_q  <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else if (accept) begin
            op_q   <= bus.req_op;
            idx_q  <= bus.req_addr[2:0];
            bit_q  <= bus.req_bit;
            err_q  <= req_err;
            rbuf_q <= 8'h00;
            if (!req_err) begin
                if (bus.req_op == OP_BYTE_RD || bus.req_op == OP_BYTE_WR)
                    addr_q <= bus.req_addr;
                else
                    addr_q <= {bus.req_addr[7:3], 3'b000};
                if (bus.req_op == OP_BYTE_WR)
                    wdata_q <= bus.req_data;
            end
        end else if (state == S_CAP) begin
            rbuf_q <= bus.sfr_rdata;
            if (!op_rd_only)
                wdata_q <= mod_byte;
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.sfr_wr_en = (state == S_WR);
    assign bus.sfr_addr  = addr_q;
    assign bus.sfr_wdata = wdata_q;
    assign bus.rsp_valid = (state == S_RSP);
    assign bus.rsp_err   = bus.rsp_valid && err_q;
    assign bus.rsp_data  = (bus.rsp_valid && !err_q && op_q != OP_BYTE_WR)
                         ? rbuf_q : 8'h00;
    assign bus.rsp_bit   = (bus.rsp_valid && !err_q && op_is_bit)
                         ? ((op_q == OP_BIT_RD) ? rbuf_q[idx_q]
                                                : wdata_q[idx_q])
                         : 1'b0;
endmodule

// File: tb/tb_sfr_bit_rmw.sv
// tb_sfr_bit_rmw: directed + random requests against a register-file
// model, checked by an arithmetic reference of SFR contents.
module tb_sfr_bit_rmw;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sfr_bit_rmw_if bus();

    sfr_bit_rmw u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rf [256];
    logic       rf_clr = 1'b1;
    logic [7:0] ref_mem [256];

    // Register file: registered read, single-cycle write.
    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 256; i++) rf[i] <= 8'h00;
            bus.sfr_rdata <= 8'h00;
        end else begin
            bus.sfr_rdata <= rf[bus.sfr_addr];
            if (bus.sfr_wr_en) rf[bus.sfr_addr] <= bus.sfr_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the register file and response must look like.
    task automatic model(input logic [2:0] op, input logic [7:0] addr,
                         input logic [7:0] data, input logic b,
                         output int lat, output logic err,
                         output logic [7:0] rdata, output logic rbit,
                         output int nwr, output int wcyc,
                         output logic [7:0] wa, output logic [7:0] wd);
        int ba, w, old, nv, bv;
        err = (addr < 8'd128) || (op == 3'd7);
        rdata = 8'h00; rbit = 1'b0; nwr = 0; wcyc = 0;
        wa = 8'h00; wd = 8'h00; lat = 1;
        if (err) begin
            lat = 1;
        end else if (op == 3'd1) begin
            lat = 2; nwr = 1; wcyc = 1; wa = addr; wd = data;
            ref_mem[addr] = data;
        end else if (op == 3'd0) begin
            lat = 3; rdata = ref_mem[addr];
        end else begin
            ba  = int'(addr) - int'(addr) % 8;
            w   = 1 << (int'(addr) % 8);
            old = int'(ref_mem[ba]);
            bv  = (old / w) % 2;
            nv  = old;
            case (op)
                3'd3: nv = bv ? old : old + w;
                3'd4: nv = bv ? old - w : old;
                3'd5: nv = bv ? old - w : old + w;
                3'd6: nv = (int'(b) == bv) ? old : (b ? old + w : old - w);
                default: nv = old;
            endcase
            rdata = 8'(old);
            rbit  = ((nv / w) % 2) == 1;
            if (op == 3'd2) begin
                lat = 3;
            end else begin
                lat = 4; nwr = 1; wcyc = 3; wa = 8'(ba); wd = 8'(nv);
                ref_mem[ba] = 8'(nv);
            end
        end
    endtask

    task automatic do_req(input string tag, input logic [2:0] op,
                          input logic [7:0] addr, input logic [7:0] data,
                          input logic b);
        int lat, nwr, wcyc, n, got_lat, got_nwr, got_wcyc, bad;
        logic err, rbit, g_err, g_bit;
        logic [7:0] rdata, wa, wd, g_data, g_wa, g_wd;
        model(op, addr, data, b, lat, err, rdata, rbit, nwr, wcyc, wa, wd);
        n = 0;
        @(negedge clock);
        while (!bus.req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_bit   = b;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_data  = 8'($urandom);
        bus.req_bit   = 1'($urandom);
        got_lat = 0; got_nwr = 0; got_wcyc = 0; bad = 0;
        g_data = 8'h00; g_bit = 1'b0; g_err = 1'b0;
        g_wa = 8'h00; g_wd = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (bus.req_ready) bad++;
            if (bus.sfr_wr_en) begin
                got_nwr++;
                if (got_nwr == 1) begin
                    got_wcyc = k; g_wa = bus.sfr_addr; g_wd = bus.sfr_wdata;
                end
            end
            if (bus.rsp_valid) begin
                got_lat = k;
                g_data = bus.rsp_data; g_bit = bus.rsp_bit;
                g_err = bus.rsp_err;
                break;
            end else if (bus.rsp_data != 0 || bus.rsp_bit || bus.rsp_err) begin
                bad++;
            end
        end
        chk({tag, " latency"}, 32'(got_lat), 32'(lat));
        chk({tag, " busy"}, 32'(bad), 32'd0);
        chk({tag, " err"}, 32'(g_err), 32'(err));
        chk({tag, " data"}, 32'(g_data), 32'(rdata));
        chk({tag, " bit"}, 32'(g_bit), 32'(rbit));
        chk({tag, " nwr"}, 32'(got_nwr), 32'(nwr));
        if (nwr != 0) begin
            chk({tag, " wcyc"}, 32'(got_wcyc), 32'(wcyc));
            chk({tag, " waddr"}, 32'(g_wa), 32'(wa));
            chk({tag, " wdata"}, 32'(g_wd), 32'(wd));
        end
    endtask

    initial begin
        int lat, nwr, wcyc, cnt, rsp_a, acc_b, lat_b;
        logic err, rbit;
        logic [7:0] rdata, wa, wd, data_b;
        logic [2:0] rop;
        logic [7:0] raddr;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 8'h00;
        bus.req_data  = 8'h00;
        bus.req_bit   = 1'b0;

        #3;
        chk("rst ready", 32'(bus.req_ready), 32'd1);
        chk("rst wr_en", 32'(bus.sfr_wr_en), 32'd0);
        chk("rst addr", 32'(bus.sfr_addr), 32'h00);
        chk("rst wdata", 32'(bus.sfr_wdata), 32'h00);
        chk("rst rsp", {29'd0, bus.rsp_valid, bus.rsp_bit, bus.rsp_err},
            32'd0);
        chk("rst rdata", 32'(bus.rsp_data), 32'h00);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rf_clr = 1'b0;
        reset  = 1'b1;

        do_req("bwr_acc", 3'd1, 8'hE0, 8'h5A, 1'b0);
        do_req("brd_acc", 3'd0, 8'hE0, 8'h00, 1'b0);
        do_req("set_e0", 3'd3, 8'hE0, 8'h00, 1'b0);
        do_req("clr_e1", 3'd4, 8'hE1, 8'h00, 1'b0);
        do_req("cpl_e7", 3'd5, 8'hE7, 8'h00, 1'b0);
        do_req("brd_d9", 3'd0, 8'hE0, 8'h00, 1'b0);
        do_req("mov_d7", 3'd6, 8'hD7, 8'h00, 1'b1);
        do_req("bitrd_d7", 3'd2, 8'hD7, 8'h00, 1'b0);
        do_req("err_ram", 3'd3, 8'h45, 8'h00, 1'b0);
        do_req("err_op7", 3'd7, 8'hE0, 8'hFF, 1'b1);

        // Reset during the write of a bit complement.
        do_req("bwr_b", 3'd1, 8'hF0, 8'h0F, 1'b0);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd5;
        bus.req_addr  = 8'hF0;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rstwr in_wr", 32'(bus.sfr_wr_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstwr wr_en", 32'(bus.sfr_wr_en), 32'd0);
        chk("rstwr ready", 32'(bus.req_ready), 32'd1);
        chk("rstwr rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rstwr addr", 32'(bus.sfr_addr), 32'h00);
        @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.sfr_wr_en) cnt++;
        end
        chk("rstwr quiet", 32'(cnt), 32'd0);
        do_req("brd_b", 3'd0, 8'hF0, 8'h00, 1'b0);

        // Back-to-back with req_valid held high.
        model(3'd1, 8'h90, 8'h33, 1'b0, lat, err, rdata, rbit, nwr, wcyc,
              wa, wd);
        model(3'd0, 8'h90, 8'h00, 1'b0, lat, err, rdata, rbit, nwr, wcyc,
              wa, wd);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        bus.req_addr  = 8'h90;
        bus.req_data  = 8'h33;
        @(posedge clock);
        #1;
        bus.req_op = 3'd0;
        rsp_a = 0; acc_b = 0; cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                acc_b = k;
                break;
            end
            if (bus.rsp_valid) rsp_a = k;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        lat_b = 0; data_b = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (bus.req_ready) cnt++;
            if (bus.rsp_valid) begin
                lat_b = k; data_b = bus.rsp_data;
                break;
            end
        end
        chk("b2b rsp_a", 32'(rsp_a), 32'd2);
        chk("b2b accept", 32'(acc_b), 32'd3);
        chk("b2b busy", 32'(cnt), 32'd0);
        chk("b2b lat_b", 32'(lat_b), 32'(lat));
        chk("b2b data_b", 32'(data_b), 32'(rdata));

        // Random requests, mostly in SFR space.
        for (int i = 0; i < 150; i++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = 8'($urandom);
            if ($urandom_range(0, 7) != 0) raddr[7] = 1'b1;
            if ($urandom_range(0, 1) == 0) raddr[7:4] = 4'hE;
            do_req("rand", rop, raddr, 8'($urandom), 1'($urandom));
        end

        @(negedge clock);
        cnt = 0;
        for (int i = 128; i < 256; i++)
            if (rf[i] !== ref_mem[i]) cnt++;
        chk("rf contents", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/sfr_bit_rmw.md
# sfr_bit_rmw

Front-end sequencer for the SFR register file. It accepts byte and bit SFR requests from the core and turns each one into a byte-wide read and/or write on the register-file bus. It accounts for the register file's one-cycle registered read (data_out is captured on the clock edge using the address present in that cycle). Bit operations on bit-addressable SFRs (ACC, B, PSW, P0–P3) are performed as read-modify-write, so the register file only ever sees whole-byte writes.

## Interface
Parameters: none.

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe; accepted when req_valid && req_ready
- req_ready  out  1  high only in IDLE
- req_op  in  3  0 BYTE_RD, 1 BYTE_WR, 2 BIT_RD, 3 BIT_SET, 4 BIT_CLR, 5 BIT_CPL, 6 BIT_MOV, 7 reserved
- req_addr  in  8  byte address (byte ops) or bit address (bit ops)
- req_data  in  8  write data for BYTE_WR
- req_bit  in  1  bit value for BIT_MOV
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  8  byte read (BYTE_RD); the pre-modify byte for bit ops; 0 for BYTE_WR
- rsp_bit  out  1  selected bit value after the operation (bit ops); 0 otherwise
- rsp_err  out  1  request rejected, no bus activity
- sfr_addr  out  8  to register file addr
- sfr_wdata  out  8  to register file data_in
- sfr_wr_en  out  1  to register file write_en (single cycle)
- sfr_rdata  in  8  from register file data_out (registered)

## Operation
- Address mapping for bit ops:
  - Byte address = {req_addr[7:3], 3'b000}.
  - Bit index = req_addr[2:0].
- Error conditions (request goes IDLE→RSP with rsp_err=1; sfr_wr_en never asserted):
  - req_addr[7]=0 for any op (internal RAM range, not handled here).
  - req_op=7.
- Request capture: op, address, data and bit are registered at acceptance. Request inputs are ignored outside IDLE.
- FSM states: IDLE, RD, CAP, WR, RSP.
  - IDLE: req_ready=1. On accept:
    - error → RSP
    - BYTE_WR → WR
    - all other ops → RD
  - RD: sfr_addr = target byte. The register file latches sfr_rdata at the end of this cycle.
  - CAP: sfr_addr held. sfr_rdata is captured into the read buffer, and the modified byte is computed:
    - SET: byte | (1<<idx)
    - CLR: byte & ~(1<<idx)
    - CPL: byte ^ (1<<idx)
    - MOV: selected bit replaced by req_bit
  - CAP transitions: BYTE_RD and BIT_RD → RSP; SET/CLR/CPL/MOV → WR.
  - WR: sfr_wr_en=1, with sfr_addr = target byte and sfr_wdata = modified byte (or req_data for BYTE_WR). Next state RSP.
  - RSP: rsp_valid=1 for exactly one cycle, rsp_* valid. Next state IDLE.
- sfr_addr holds its last value in IDLE. sfr_wdata changes only on entry to WR.
- rsp_data, rsp_bit and rsp_err are valid only while rsp_valid=1; they are 0 otherwise.

## Timing
- Latency, counted from the acceptance edge (cycle 0) to the rsp_valid cycle:
  - error: 1
  - BYTE_WR: 2 (WR in cycle 1)
  - BYTE_RD / BIT_RD: 3
  - SET/CLR/CPL/MOV: 4 (WR in cycle 3)
- Throughput: one request in flight. req_ready returns high in the cycle after rsp_valid, so the next accept is possible in that cycle.
- Reset (low): asynchronously forces:
  - state IDLE, req_ready=1
  - sfr_wr_en=0, sfr_addr=0x00, sfr_wdata=0x00
  - rsp_valid=0, rsp_data=0x00, rsp_bit=0, rsp_err=0
- Reset mid-operation: the in-flight request is dropped with no response. If reset is asserted during WR, sfr_wr_en drops immediately. No write is issued after reset deasserts.
- Write-then-read of the same SFR on back-to-back requests returns the new value: the write completes in WR, before the next RD.

## Test plan
- After reset, ACC=0x00: BYTE_WR 0xE0 data 0x5A → sfr_wr_en for 1 cycle at cycle 1 with addr 0xE0/wdata 0x5A; rsp_valid at cycle 2; a following BYTE_RD 0xE0 returns rsp_data 0x5A at cycle 3.
- ACC=0x5A: BIT_SET 0xE0 → write 0x5B to 0xE0 at cycle 3; rsp_bit=1, rsp_data=0x5A at cycle 4. Then BIT_CLR 0xE1 → 0x59. Then BIT_CPL 0xE7 → 0xD9.
- PSW=0x00: BIT_MOV 0xD7 with req_bit=1 → write 0x80 to 0xD0; subsequent BIT_RD 0xD7 → rsp_bit=1, no sfr_wr_en.
- BIT_SET 0x45 and op=7 at 0xE0 → rsp_err=1 at cycle 1; sfr_wr_en stays 0; rsp_data=0.
- Reset pulsed low during WR of BIT_CPL 0xF0 (B=0x0F) → sfr_wr_en drops at once; no rsp_valid; B stays 0x0F; req_ready=1.
- Back-to-back: req_valid held high with two requests → second accepted only in the cycle after the first rsp_valid; req_ready=0 throughout busy states.
